// File: rtl/m_stage_lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: memory op codes,
// exception codes and FSM states.
package m_stage_lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } lsu_state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Op codes 9-15 are unassigned and behave as NONE.
  function automatic mem_op_e decode_op(input logic [3:0] raw);
    return (raw > 4'd8) ? OP_NONE : mem_op_e'(raw);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension for the M-stage LSU.
module lsu_load_ext
  import m_stage_lsu_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{a, 3'b000} +: 8];
    lane_h = a[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LW:   data = rdata;
      OP_LH:   data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data = {16'h0000, lane_h};
      OP_LB:   data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data = {24'h000000, lane_b};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/m_stage_lsu.sv
// M-stage load/store unit: req/ack data-memory handshake with pipeline stall.
// Optional LSU_MISALIGN_EXC_EN raises AdEL/AdES on misaligned accesses.
module m_stage_lsu
  import m_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [3:0]  M_mem_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  input  logic        stage_advance,
  output logic        lsu_busy,
  output logic [31:0] M_DMout,
  output logic        M_bus_err,
  output logic [4:0]  M_exc_code,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  lsu_state_e    state, state_n;
  mem_op_e       op_in, op_q;
  logic          live, misalign, timeout;
  logic [1:0]    a_in, a_q;
  logic [3:0]    be_in, be_q;
  logic [31:0]   wdata_in, wdata_q, addr_q, data_q, ext_data;
  logic          we_q, err_q;
  logic [CW-1:0] cnt;

  assign op_in = decode_op(M_mem_op);
  assign live  = M_valid & (op_in != OP_NONE);

`ifdef LSU_MISALIGN_EXC_EN
  logic [4:0] exc_q;

  assign a_in     = M_addr[1:0];
  assign misalign = (((op_in == OP_LW) || (op_in == OP_SW)) && (a_in != 2'b00)) ||
                    (((op_in == OP_LH) || (op_in == OP_LHU) || (op_in == OP_SH)) && a_in[0]);
`else
  // Without the exception, low address bits are snapped to the access size.
  always_comb begin
    a_in = M_addr[1:0];
    case (op_in)
      OP_LW, OP_SW:         a_in = 2'b00;
      OP_LH, OP_LHU, OP_SH: a_in[0] = 1'b0;
      default: ;
    endcase
  end
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_in    = '0;
    wdata_in = '0;
    case (op_in)
      OP_SB: begin
        be_in    = 4'b0001 << a_in;
        wdata_in = {4{M_wdata[7:0]}};
      end
      OP_SH: begin
        be_in    = a_in[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{M_wdata[15:0]}};
      end
      OP_SW: begin
        be_in    = '1;
        wdata_in = M_wdata;
      end
      default: ;
    endcase
  end

  lsu_load_ext u_load_ext (
    .op    (op_q),
    .a     (a_q),
    .rdata (dm_rdata),
    .data  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    lsu_busy = 1'b0;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        lsu_busy = live;
        if (live) state_n = misalign ? S_DONE : S_REQ;
      end
      S_REQ: begin
        lsu_busy = 1'b1;
        if (dm_ack) begin
          state_n = S_DONE;
        end else if ((TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1))) begin
          timeout = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (stage_advance) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_NONE;
      a_q     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (live) begin
            op_q    <= op_in;
            a_q     <= a_in;
            addr_q  <= {M_addr[31:2], 2'b00};
            be_q    <= be_in;
            wdata_q <= wdata_in;
            we_q    <= is_store(op_in);
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
          end
        end
        S_REQ: begin
          if (dm_ack)       data_q <= ext_data;
          else if (timeout) err_q  <= 1'b1;
          else              cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= EXC_NONE;
    end else if ((state == S_IDLE) && live) begin
      if (misalign) exc_q <= is_store(op_in) ? EXC_ADES : EXC_ADEL;
      else          exc_q <= EXC_NONE;
    end
  end
  assign M_exc_code = (state == S_DONE) ? exc_q : EXC_NONE;
`else
  assign M_exc_code = '0;
`endif

  assign M_DMout   = (state == S_DONE) ? data_q : '0;
  assign M_bus_err = (state == S_DONE) & err_q;
  assign dm_req    = (state == S_REQ);
  assign dm_we     = we_q;
  assign dm_addr   = addr_q;
  assign dm_be     = be_q;
  assign dm_wdata  = wdata_q;

endmodule

// File: tb/tb_m_stage_lsu.sv
// Directed self-checking bench for m_stage_lsu (default and TIMEOUT_CYC=4 builds).
module tb_m_stage_lsu;

  logic        clk;
  logic        reset;
  logic        M_valid;
  logic [3:0]  M_mem_op;
  logic [31:0] M_addr;
  logic [31:0] M_wdata;
  logic        stage_advance;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        lsu_busy, M_bus_err, dm_req, dm_we;
  logic [31:0] M_DMout, dm_addr, dm_wdata;
  logic [4:0]  M_exc_code;
  logic [3:0]  dm_be;

  logic        lsu_busy_t, M_bus_err_t, dm_req_t, dm_we_t;
  logic [31:0] M_DMout_t, dm_addr_t, dm_wdata_t;
  logic [4:0]  M_exc_code_t;
  logic [3:0]  dm_be_t;

  int unsigned n_checks;
  int unsigned n_fail;

  int unsigned busy_n;
  int unsigned req_n;
  logic        stable;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  m_stage_lsu u_dut (
    .clk           (clk),
    .reset         (reset),
    .M_valid       (M_valid),
    .M_mem_op      (M_mem_op),
    .M_addr        (M_addr),
    .M_wdata       (M_wdata),
    .stage_advance (stage_advance),
    .lsu_busy      (lsu_busy),
    .M_DMout       (M_DMout),
    .M_bus_err     (M_bus_err),
    .M_exc_code    (M_exc_code),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_be         (dm_be),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata)
  );

  m_stage_lsu #(.TIMEOUT_CYC(4)) u_dut_to (
    .clk           (clk),
    .reset         (reset),
    .M_valid       (M_valid),
    .M_mem_op      (M_mem_op),
    .M_addr        (M_addr),
    .M_wdata       (M_wdata),
    .stage_advance (stage_advance),
    .lsu_busy      (lsu_busy_t),
    .M_DMout       (M_DMout_t),
    .M_bus_err     (M_bus_err_t),
    .M_exc_code    (M_exc_code_t),
    .dm_req        (dm_req_t),
    .dm_we         (dm_we_t),
    .dm_addr       (dm_addr_t),
    .dm_be         (dm_be_t),
    .dm_wdata      (dm_wdata_t),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one access in IDLE and runs it to DONE; ack_cyc = REQ cycle
  // (1-based) in which dm_ack is given, 0 = never.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned ack_cyc, input logic [31:0] rdata);
    M_valid       = 1'b1;
    M_mem_op      = op;
    M_addr        = addr;
    M_wdata       = wd;
    dm_rdata      = rdata;
    dm_ack        = 1'b0;
    stage_advance = 1'b0;
    busy_n        = 0;
    req_n         = 0;
    stable        = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!lsu_busy) break;
      busy_n++;
      if (dm_req) begin
        req_n++;
        if (req_n == 1) begin
          cap_addr  = dm_addr;
          cap_be    = dm_be;
          cap_wdata = dm_wdata;
          cap_we    = dm_we;
        end else if (dm_addr !== cap_addr || dm_be !== cap_be ||
                     dm_wdata !== cap_wdata || dm_we !== cap_we) begin
          stable = 1'b0;
        end
        dm_ack = (req_n == ack_cyc);
      end
      @(posedge clk);
      #1;
      dm_ack = 1'b0;
    end
  endtask

  task automatic advance_out();
    stage_advance = 1'b1;
    @(posedge clk);
    #1;
    stage_advance = 1'b0;
    M_valid       = 1'b0;
    M_mem_op      = 4'd0;
  endtask

  initial begin
    int unsigned busy_t_n;
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    M_valid       = 1'b0;
    M_mem_op      = 4'd0;
    M_addr        = '0;
    M_wdata       = '0;
    stage_advance = 1'b0;
    dm_ack        = 1'b0;
    dm_rdata      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",  32'(lsu_busy), 32'd0);
    check_eq("rst_req",   32'(dm_req), 32'd0);
    check_eq("rst_dmout", M_DMout, 32'd0);
    check_eq("rst_err",   32'(M_bus_err), 32'd0);
    check_eq("rst_exc",   32'(M_exc_code), 32'd0);
    check_eq("rst_dmbus", {dm_be, 3'b000, dm_we, dm_wdata[23:0]} | dm_addr, 32'd0);
    reset = 1'b0;

    // LB @..03, ack in first REQ cycle
    do_access(4'd4, 32'h0000_1003, 32'h0, 1, 32'h80FF_0102);
    check_eq("lb_busy",  busy_n, 32'd2);
    check_eq("lb_data",  M_DMout, 32'hFFFF_FF80);
    check_eq("lb_be",    32'(cap_be), 32'h0);
    check_eq("lb_addr",  cap_addr, 32'h0000_1000);
    check_eq("lb_err",   32'(M_bus_err), 32'd0);
    advance_out();

    // SH @..02
    do_access(4'd7, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h5555_5555);
    check_eq("sh_be",    32'(cap_be), 32'hC);
    check_eq("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check_eq("sh_we",    32'(cap_we), 32'd1);
    check_eq("sh_dmout", M_DMout, 32'd0);
    advance_out();

    // SB @..01
    do_access(4'd8, 32'h0000_4001, 32'h1234_565A, 1, 32'h0);
    check_eq("sb_be",    32'(cap_be), 32'h2);
    check_eq("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    advance_out();

    // LW with ack in fifth REQ cycle, then DONE held for 3 cycles
    do_access(4'd1, 32'h0000_3008, 32'h0, 5, 32'hDEAD_BEEF);
    check_eq("lw_busy",   busy_n, 32'd6);
    check_eq("lw_reqs",   req_n, 32'd5);
    check_eq("lw_stable", 32'(stable), 32'd1);
    check_eq("lw_addr",   cap_addr, 32'h0000_3008);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_data", M_DMout, 32'hDEAD_BEEF);
      check_eq("hold_busy", 32'(lsu_busy), 32'd0);
    end
    dm_ack = 1'b0;
    advance_out();
    #1;
    check_eq("idle_dmout", M_DMout, 32'd0);
    check_eq("idle_busy",  32'(lsu_busy), 32'd0);

    // Halfword/byte loads with extension
    do_access(4'd2, 32'h0000_5002, 32'h0, 1, 32'h80FF_0102);
    check_eq("lh_data", M_DMout, 32'hFFFF_80FF);
    advance_out();
    do_access(4'd3, 32'h0000_5002, 32'h0, 2, 32'h80FF_0102);
    check_eq("lhu_data", M_DMout, 32'h0000_80FF);
    check_eq("lhu_busy", busy_n, 32'd3);
    advance_out();
    do_access(4'd5, 32'h0000_5001, 32'h0, 1, 32'h80FF_0102);
    check_eq("lbu_data", M_DMout, 32'h0000_0001);
    advance_out();

    // NONE op (code 12) and invalid SW stay idle
    M_valid  = 1'b1;
    M_mem_op = 4'd12;
    #1;
    check_eq("none_busy", 32'(lsu_busy), 32'd0);
    @(posedge clk);
    #1;
    check_eq("none_req",   32'(dm_req), 32'd0);
    check_eq("none_dmout", M_DMout, 32'd0);
    M_valid  = 1'b0;
    M_mem_op = 4'd6;
    #1;
    check_eq("inv_busy", 32'(lsu_busy), 32'd0);
    @(posedge clk);
    #1;
    check_eq("inv_req", 32'(dm_req), 32'd0);
    M_mem_op = 4'd0;

    // Misaligned LW @..01
`ifdef LSU_MISALIGN_EXC_EN
    do_access(4'd1, 32'h0000_8001, 32'h0, 1, 32'hCAFE_F00D);
    check_eq("mis_reqs",  req_n, 32'd0);
    check_eq("mis_busy",  busy_n, 32'd1);
    check_eq("mis_exc",   32'(M_exc_code), 32'd4);
    check_eq("mis_dmout", M_DMout, 32'd0);
    advance_out();
`else
    do_access(4'd1, 32'h0000_8001, 32'h0, 1, 32'hCAFE_F00D);
    check_eq("mis_addr",  cap_addr, 32'h0000_8000);
    check_eq("mis_exc",   32'(M_exc_code), 32'd0);
    check_eq("mis_dmout", M_DMout, 32'hCAFE_F00D);
    advance_out();
    do_access(4'd7, 32'h0000_8003, 32'h0000_1234, 1, 32'h0);
    check_eq("mis_sh_be", 32'(cap_be), 32'hC);
    advance_out();
`endif

    // Timeout on the TIMEOUT_CYC=4 instance, no ack
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    M_valid       = 1'b1;
    M_mem_op      = 4'd1;
    M_addr        = 32'h0000_6000;
    dm_ack        = 1'b0;
    stage_advance = 1'b0;
    busy_t_n      = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!lsu_busy_t) break;
      busy_t_n++;
      @(posedge clk);
      #1;
    end
    check_eq("to_busy",  busy_t_n, 32'd5);
    check_eq("to_err",   32'(M_bus_err_t), 32'd1);
    check_eq("to_dmout", M_DMout_t, 32'd0);
    check_eq("to_long_req", 32'(dm_req), 32'd1);

    // Reset while REQ, then a stray ack
    reset   = 1'b1;
    M_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstreq_req", 32'(dm_req), 32'd0);
    reset    = 1'b0;
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check_eq("stray_req",   32'(dm_req), 32'd0);
    check_eq("stray_dmout", M_DMout, 32'd0);
    dm_ack = 1'b0;
    do_access(4'd4, 32'h0000_7000, 32'h0, 1, 32'h0000_007F);
    check_eq("post_data", M_DMout, 32'h0000_007F);
    check_eq("post_busy", busy_n, 32'd2);
    advance_out();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
